reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter AW, default 5, address width; register count NREG = 2**AW.
REQ-003 Parameter BYPASS, default 1; 1 = write-first forwarding to read ports, 0 = read-old.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 we  in  1  write enable.
REQ-008 wa  in  AW  write address.
REQ-009 wd  in  XLEN  write data.
REQ-010 ra1, ra2  in  AW each  read addresses.
REQ-011 rd1, rd2  out  XLEN each  registered read data.
REQ-012 sb_set  in  1  mark register sb_addr pending (an in-flight write was issued).
REQ-013 sb_addr  in  AW  scoreboard set address.
REQ-014 busy1, busy2  out  1 each  combinational pending status of ra1 / ra2.
REQ-015 ready  out  1  high once the init sweep completes.

Function
REQ-016 FSM states: INIT (clear sweep) and RUN; rst forces INIT with sweep counter = 0.
REQ-017 INIT: each cycle, register[counter] is written 0 and the counter increments; after register NREG-1 is cleared, the FSM enters RUN; ready = 1 from the cycle after that clear, i.e. exactly NREG cycles after rst deasserts.
REQ-018 INIT: we and sb_set are ignored; rd1/rd2 update to 0; busy1/busy2 = 0.
REQ-019 RUN: we=1 with wa≠0 writes wd to register[wa] at the edge; writes to address 0 are discarded.
REQ-020 Register 0 SHALL always read 0, with busy 0, regardless of writes or sb_set.
REQ-021 Reads: rd1/rd2 take register[ra1]/[ra2] at the edge; 1-cycle latency; outputs hold between edges.
REQ-022 BYPASS=1: if we=1, wa≠0 and wa==raN in the same cycle, rdN captures wd; BYPASS=0: rdN captures the old value.
REQ-023 Scoreboard: one pending bit per register; sb_set=1 (RUN, sb_addr≠0) sets bit[sb_addr]; a RUN write with we=1 clears bit[wa].
REQ-024 Simultaneous sb_set and write to the same address: set wins (bit = 1 after the edge); different addresses: both take effect.
REQ-025 busyN = pending bit[raN], combinational, reflecting state before the current edge (no same-cycle bypass of set/clear).
REQ-026 Both read ports may address the same register; both return identical data.

Reset
REQ-027 rst high at an edge: FSM = INIT, counter = 0, all pending bits = 0, rd1 = rd2 = 0, ready = 0.
REQ-028 Register contents are not cleared by rst directly; the sweep clears them over the following NREG cycles.
REQ-029 rst asserted mid-sweep or in RUN restarts the sweep from register 0; rst held high keeps the counter at 0.

Verification
REQ-030 Release rst, idle -> ready = 0 for 32 cycles, ready = 1 on cycle 32; any ra reads 0 afterwards.
REQ-031 RUN: write x5 = 0x00000005, next cycle ra1 = 5 -> rd1 = 0x00000005 one edge later; write x0 = 0xFFFFFFFF -> rd of x0 = 0.
REQ-032 BYPASS=1: we=1, wa=6, wd=0x4, ra2=6 in the same cycle -> rd2 = 0x4 after the edge; BYPASS=0, old value 0x0 -> rd2 = 0x0.
REQ-033 sb_set on x7 -> busy1 = 1 with ra1 = 7 next cycle; write x7 -> busy1 = 0 following the edge; same-cycle sb_set x7 + write x7 -> busy stays 1.
REQ-034 rst pulse at sweep counter = 10, then release -> ready rises 32 cycles after release; previously written x5 reads 0.
REQ-035 we=1 during INIT, wa=3, wd=0xA -> ignored; x3 reads 0 after ready.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read / 1-write register file with a clear sweep after reset
// and a per-register pending scoreboard. Register 0 is hard-wired to zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | clear sweep: register[cnt] <= 0 each cycle, writes/sets ignored
// RUN   | normal operation: writes, registered reads, scoreboard active
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    output logic            busy1,
    output logic            busy2,
    output logic            ready
);

    localparam int NREG = 2 ** AW;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_nxt;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;
    logic [XLEN-1:0] rd1_nxt;
    logic [XLEN-1:0] rd2_nxt;
    logic            run;
    logic            wr_en;
    logic            set_en;

    assign run    = (state == RUN);
    assign wr_en  = run && we && (wa != '0);
    assign set_en = run && sb_set && (sb_addr != '0);

    // FSM state and sweep counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep advances one register per cycle; last register hands over to RUN
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = cnt + AW'(1);
            if (cnt == AW'(NREG - 1)) begin
                state_nxt = RUN;
            end
        end
    end

    // Register array: no reset, cleared by the sweep instead
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                regs[cnt] <= '0;
            end else if (wr_en) begin
                regs[wa] <= wd;
            end
        end
    end

    // Read-port next values; x0 is forced to zero so it never depends on storage
    always_comb begin
        rd1_nxt = '0;
        rd2_nxt = '0;
        if (run) begin
            if ((BYPASS != 0) && wr_en && (wa == ra1)) begin
                rd1_nxt = wd;
            end else if (ra1 != '0) begin
                rd1_nxt = regs[ra1];
            end
            if ((BYPASS != 0) && wr_en && (wa == ra2)) begin
                rd2_nxt = wd;
            end else if (ra2 != '0) begin
                rd2_nxt = regs[ra2];
            end
        end
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            rd1 <= rd1_nxt;
            rd2 <= rd2_nxt;
        end
    end

    // Pending scoreboard: the set is applied after the clear so it wins on a tie
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (wr_en) begin
                pending[wa] <= 1'b0;
            end
            if (set_en) begin
                pending[sb_addr] <= 1'b1;
            end
        end
    end

    assign busy1 = run && pending[ra1];
    assign busy2 = run && pending[ra2];
    assign ready = run;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb. Two instances share the
// same stimulus, one forwarding (BYPASS=1) and one read-old (BYPASS=0).
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            we = 1'b0;
    logic            sb_set = 1'b0;
    logic [AW-1:0]   wa = '0;
    logic [AW-1:0]   ra1 = '0;
    logic [AW-1:0]   ra2 = '0;
    logic [AW-1:0]   sb_addr = '0;
    logic [XLEN-1:0] wd = '0;

    logic [XLEN-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic            busy1_a, busy2_a, busy1_b, busy2_b, ready_a, ready_b;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .busy1(busy1_a), .busy2(busy2_a), .ready(ready_a)
    );

    reg_file_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .busy1(busy1_b), .busy2(busy2_b), .ready(ready_b)
    );

    typedef struct {
        logic [XLEN-1:0] rd1a;
        logic [XLEN-1:0] rd2a;
        logic [XLEN-1:0] rd1b;
        logic [XLEN-1:0] rd2b;
        logic            rdy;
    } out_t;

    typedef struct {
        logic b1;
        logic b2;
    } busy_t;

    out_t  out_q  [$];
    busy_t busy_q [$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: register contents, pending flags, cycles since release
    logic [XLEN-1:0] mem  [NREG];
    bit              pend [NREG];
    int              rel = 0;
    out_t            nxt;
    bit              primed = 1'b0;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: publish the previous edge's expected outputs,
    // drive new inputs, publish expected busy, then advance the model.
    task automatic step(input bit r, input bit w, input int a, input logic [XLEN-1:0] d,
                        input int r1, input int r2, input bit s, input int sa);
        busy_t b;
        bit    hit1;
        bit    hit2;
        @(posedge clk);
        #1;
        if (primed) out_q.push_back(nxt);
        rst     = r;
        we      = w;
        wa      = AW'(a);
        wd      = d;
        ra1     = AW'(r1);
        ra2     = AW'(r2);
        sb_set  = s;
        sb_addr = AW'(sa);
        if (primed) begin
            b.b1 = (rel >= NREG) && pend[r1];
            b.b2 = (rel >= NREG) && pend[r2];
            busy_q.push_back(b);
        end
        if (r) begin
            rel = 0;
            foreach (pend[i]) pend[i] = 1'b0;
            nxt.rd1a = '0; nxt.rd2a = '0; nxt.rd1b = '0; nxt.rd2b = '0;
            nxt.rdy  = 1'b0;
        end else if (rel < NREG) begin
            rel++;
            nxt.rd1a = '0; nxt.rd2a = '0; nxt.rd1b = '0; nxt.rd2b = '0;
            if (rel == NREG) begin
                foreach (mem[i]) mem[i] = '0;
            end
            nxt.rdy = (rel >= NREG);
        end else begin
            hit1 = w && (a != 0) && (a == r1);
            hit2 = w && (a != 0) && (a == r2);
            nxt.rd1b = mem[r1];
            nxt.rd2b = mem[r2];
            nxt.rd1a = hit1 ? d : mem[r1];
            nxt.rd2a = hit2 ? d : mem[r2];
            if (w && (a != 0)) begin
                mem[a]  = d;
                pend[a] = 1'b0;
            end
            if (s && (sa != 0)) pend[sa] = 1'b1;
            nxt.rdy = 1'b1;
        end
        primed = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, i % NREG, (i + 7) % NREG, 0, 0);
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREG - 1));
        return int'($urandom_range(0, 7));
    endfunction

    // Monitor: compares whatever expectations the driver has published
    initial begin
        busy_t b;
        out_t  o;
        forever begin
            @(negedge clk);
            if (busy_q.size() > 0) begin
                b = busy_q.pop_front();
                check("busy1_a", 32'(busy1_a), 32'(b.b1));
                check("busy2_a", 32'(busy2_a), 32'(b.b2));
                check("busy1_b", 32'(busy1_b), 32'(b.b1));
                check("busy2_b", 32'(busy2_b), 32'(b.b2));
            end
            if (out_q.size() > 0) begin
                o = out_q.pop_front();
                check("rd1_bypass",  rd1_a, o.rd1a);
                check("rd2_bypass",  rd2_a, o.rd2a);
                check("rd1_readold", rd1_b, o.rd1b);
                check("rd2_readold", rd2_b, o.rd2b);
                check("ready_a", 32'(ready_a), 32'(o.rdy));
                check("ready_b", 32'(ready_b), 32'(o.rdy));
            end
        end
    end

    // Stimulus
    initial begin
        step(1, 0, 0, '0, 0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0, 0);
        idle(NREG + 2);
        for (int i = 0; i < NREG; i++) step(0, 0, 0, '0, i, NREG - 1 - i, 0, 0);

        step(0, 1, 5, 32'h0000_0005, 0, 0, 0, 0);
        step(0, 0, 0, '0, 5, 5, 0, 0);
        step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        step(0, 0, 0, '0, 0, 0, 0, 0);

        step(0, 1, 6, 32'h0000_0004, 6, 6, 0, 0);
        step(0, 0, 0, '0, 6, 6, 0, 0);

        step(0, 0, 0, '0, 0, 0, 1, 7);
        step(0, 0, 0, '0, 7, 7, 0, 0);
        step(0, 1, 7, 32'h0000_0077, 7, 7, 0, 0);
        step(0, 0, 0, '0, 7, 7, 0, 0);
        step(0, 1, 7, 32'h0000_0078, 7, 7, 1, 7);
        step(0, 0, 0, '0, 7, 7, 1, 0);
        step(0, 0, 0, '0, 7, 0, 0, 0);

        step(1, 0, 0, '0, 0, 0, 0, 0);
        idle(10);
        step(1, 0, 0, '0, 5, 3, 0, 0);
        for (int i = 0; i < NREG; i++) step(0, 1, 3, 32'h0000_000A, 3, 5, 1, 3);
        step(0, 0, 0, '0, 5, 3, 0, 0);
        step(0, 0, 0, '0, 3, 5, 0, 0);
        step(0, 0, 0, '0, 3, 5, 0, 0);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), rnd_addr(),
                 $urandom(), rnd_addr(), rnd_addr(), ($urandom_range(0, 2) == 0), rnd_addr());
        end

        idle(2);
        repeat (3) @(posedge clk);
        #1;
        check("out_q_drain", 32'(out_q.size()), 32'd0);
        check("busy_q_drain", 32'(busy_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
